// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, drives the instruction memory address and fills the
// IF/ID register toward decode under a valid/ready handshake.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES = 164,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc_plus4,
    output logic        id_fault,
    output logic [31:0] fetch_count
);

    localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_BYTES);
    localparam logic [31:0] PC_STEP    = 32'd4;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_FAULT = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic [31:0] id_pc_plus4_q, id_pc_plus4_d;
    logic        id_fault_q, id_fault_d;
    logic [31:0] fetch_count_q, fetch_count_d;
    // Set by a misaligned redirect: FAULT must still present one fault NOP.
    logic        fault_load_q, fault_load_d;

    logic        transfer_c;
    logic        advance_c;
    logic        in_range_c;

    assign transfer_c = id_valid_q & id_ready;
    assign advance_c  = ~id_valid_q | id_ready;
    assign in_range_c = (pc_q < IMEM_LIMIT);

    // Next-state: redirect wins, then BOOT/RUN/FAULT behaviour.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        id_valid_d    = id_valid_q;
        id_pc_d       = id_pc_q;
        id_instr_d    = id_instr_q;
        id_pc_plus4_d = id_pc_plus4_q;
        id_fault_d    = id_fault_q;
        fetch_count_d = fetch_count_q;
        fault_load_d  = fault_load_q;

        if (transfer_c) begin
            fetch_count_d = fetch_count_q + 32'd1;
            id_valid_d    = 1'b0;
        end

        if (redirect_valid) begin
            id_valid_d = 1'b0;
            pc_d       = redirect_pc;
            if (redirect_pc[1:0] == 2'b00) begin
                state_d      = S_RUN;
                fault_load_d = 1'b0;
            end else begin
                state_d      = S_FAULT;
                fault_load_d = 1'b1;
            end
        end else begin
            case (state_q)
                S_BOOT: state_d = S_RUN;
                S_RUN: begin
                    if (advance_c) begin
                        id_valid_d    = 1'b1;
                        id_pc_d       = pc_q;
                        id_pc_plus4_d = pc_q + PC_STEP;
                        if (in_range_c) begin
                            id_instr_d = imem_rdata;
                            id_fault_d = 1'b0;
                            pc_d       = pc_q + PC_STEP;
                        end else begin
                            id_instr_d = NOP_INSTR;
                            id_fault_d = 1'b1;
                            state_d    = S_FAULT;
                        end
                    end
                end
                S_FAULT: begin
                    if (fault_load_q && advance_c) begin
                        id_valid_d    = 1'b1;
                        id_pc_d       = pc_q;
                        id_pc_plus4_d = pc_q + PC_STEP;
                        id_instr_d    = NOP_INSTR;
                        id_fault_d    = 1'b1;
                        fault_load_d  = 1'b0;
                    end
                end
                default: state_d = S_BOOT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_BOOT;
            pc_q          <= RESET_PC;
            id_valid_q    <= 1'b0;
            id_pc_q       <= 32'd0;
            id_instr_q    <= NOP_INSTR;
            id_pc_plus4_q <= 32'd0;
            id_fault_q    <= 1'b0;
            fetch_count_q <= 32'd0;
            fault_load_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            id_valid_q    <= id_valid_d;
            id_pc_q       <= id_pc_d;
            id_instr_q    <= id_instr_d;
            id_pc_plus4_q <= id_pc_plus4_d;
            id_fault_q    <= id_fault_d;
            fetch_count_q <= fetch_count_d;
            fault_load_q  <= fault_load_d;
        end
    end

    assign imem_addr   = pc_q;
    assign id_valid    = id_valid_q;
    assign id_pc       = id_pc_q;
    assign id_instr    = id_instr_q;
    assign id_pc_plus4 = id_pc_plus4_q;
    assign id_fault    = id_fault_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a transaction-level model of what
// decode should see is compared against the DUT after every clock edge.
module tb_instruction_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int unsigned MEM_BYTES = 164;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic [31:0] id_pc_plus4;
    logic        id_fault;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [41];

    // Model of decode-visible state.
    logic        m_valid;
    logic [31:0] m_ipc, m_instr, m_p4, m_count, m_pc;
    logic        m_fault;
    bit          m_boot, m_halted, m_pend;

    instruction_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_instr       (id_instr),
        .id_pc_plus4    (id_pc_plus4),
        .id_fault       (id_fault),
        .fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        if (addr < 32'(MEM_BYTES)) return mem[int'(addr[31:2])];
        return 32'hDEAD_BEEF;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_ipc = 32'd0; m_instr = NOP; m_p4 = 32'd0;
        m_fault = 1'b0; m_count = 32'd0; m_pc = 32'd0;
        m_boot = 1'b1; m_halted = 1'b0; m_pend = 1'b0;
    endtask

    task automatic present(input logic [31:0] pc, input logic [31:0] instr, input logic flt);
        m_valid = 1'b1; m_ipc = pc; m_p4 = pc + 32'd4; m_instr = instr; m_fault = flt;
    endtask

    // One clock edge as seen by decode: consume, then redirect or deliver.
    task automatic model_edge();
        bit took;
        took = m_valid && id_ready;
        if (took) m_count = m_count + 32'd1;
        if (redirect_valid) begin
            m_valid  = 1'b0;
            m_pc     = redirect_pc;
            m_halted = (redirect_pc % 4) != 0;
            m_pend   = m_halted;
            m_boot   = 1'b0;
        end else if (m_boot) begin
            m_boot = 1'b0;
        end else if (m_pend && (!m_valid || id_ready)) begin
            present(m_pc, NOP, 1'b1);
            m_pend = 1'b0;
        end else if (!m_halted && (!m_valid || id_ready)) begin
            if (m_pc < 32'(MEM_BYTES)) begin
                present(m_pc, mem_word(m_pc), 1'b0);
                m_pc = m_pc + 32'd4;
            end else begin
                present(m_pc, NOP, 1'b1);
                m_halted = 1'b1;
            end
        end else if (took) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic compare_all();
        chk("id_valid", 32'(id_valid), 32'(m_valid));
        chk("id_pc", id_pc, m_ipc);
        chk("id_instr", id_instr, m_instr);
        chk("id_pc_plus4", id_pc_plus4, m_p4);
        chk("id_fault", 32'(id_fault), 32'(m_fault));
        chk("fetch_count", fetch_count, m_count);
        chk("imem_addr", imem_addr, m_pc);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic lit_reset(input string tag);
        chk({tag, "_valid"}, 32'(id_valid), 32'd0);
        chk({tag, "_pc"}, id_pc, 32'd0);
        chk({tag, "_instr"}, id_instr, 32'h0000_0013);
        chk({tag, "_p4"}, id_pc_plus4, 32'd0);
        chk({tag, "_fault"}, 32'(id_fault), 32'd0);
        chk({tag, "_count"}, fetch_count, 32'd0);
        chk({tag, "_addr"}, imem_addr, 32'd0);
    endtask

    task automatic redirect(input logic [31:0] target);
        redirect_valid = 1'b1; redirect_pc = target;
        step();
        redirect_valid = 1'b0;
    endtask

    initial begin
        mem[0] = 32'h00c1_0093; mem[1] = 32'h0020_8193;
        mem[2] = 32'h0031_0213; mem[3] = 32'h0041_8293;
        for (int i = 4; i < 41; i++) mem[i] = 32'h0A00_0000 + 32'(i);

        rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0; id_ready = 1'b1;
        model_reset();
        #12;
        lit_reset("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Boot cycle, then sequential delivery.
        step();
        chk("boot_idle", 32'(id_valid), 32'd0);
        step();
        chk("first_valid", 32'(id_valid), 32'd1);
        chk("first_pc", id_pc, 32'd0);
        chk("first_instr", id_instr, 32'h00c1_0093);
        step();
        chk("pc4", id_pc, 32'd4);
        chk("pc4_instr", id_instr, 32'h0020_8193);
        step();
        chk("pc8", id_pc, 32'd8);
        chk("pc8_instr", id_instr, 32'h0031_0213);

        // Three-cycle stall at pc 8.
        id_ready = 1'b0;
        repeat (3) step();
        chk("stall_pc", id_pc, 32'd8);
        chk("stall_addr", imem_addr, 32'd12);
        chk("stall_count", fetch_count, 32'd2);
        id_ready = 1'b1;
        step();
        chk("resume_pc", id_pc, 32'd12);
        chk("resume_instr", id_instr, 32'h0041_8293);
        step();
        chk("count4", fetch_count, 32'd4);

        // Redirect coinciding with a transfer.
        redirect(32'h40);
        chk("redir_flush", 32'(id_valid), 32'd0);
        chk("redir_count", fetch_count, 32'd5);
        step();
        chk("redir_pc", id_pc, 32'h40);
        chk("redir_instr", id_instr, 32'h0A00_0010);

        // Misaligned redirect while stalled: no transfer counted.
        id_ready = 1'b0;
        step();
        redirect(32'h42);
        chk("mis_count", fetch_count, 32'd5);
        id_ready = 1'b1;
        step();
        chk("mis_fault", 32'(id_fault), 32'd1);
        chk("mis_instr", id_instr, 32'h0000_0013);
        chk("mis_pc", id_pc, 32'h42);
        repeat (3) step();
        chk("mis_idle", 32'(id_valid), 32'd0);
        chk("mis_hold", imem_addr, 32'h42);
        redirect(32'h0);
        step();
        chk("recover_pc", id_pc, 32'd0);

        // End of memory: 160 is valid, 164 faults and parks.
        redirect(32'd152);
        repeat (3) step();
        chk("last_pc", id_pc, 32'd160);
        chk("last_instr", id_instr, 32'h0A00_0028);
        step();
        chk("oor_fault", 32'(id_fault), 32'd1);
        chk("oor_pc", id_pc, 32'd164);
        id_ready = 1'b0;
        step();
        id_ready = 1'b1;
        repeat (3) step();
        chk("oor_hold", imem_addr, 32'd164);
        chk("oor_idle", 32'(id_valid), 32'd0);

        // Asynchronous reset in the middle of a stall.
        redirect(32'h0);
        step();
        id_ready = 1'b0;
        repeat (2) step();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        lit_reset("async");
        @(negedge clk);
        compare_all();
        // Redirect issued in the boot cycle skips boot.
        rst_n = 1'b1; id_ready = 1'b1;
        redirect(32'd8);
        chk("boot_redir_idle", 32'(id_valid), 32'd0);
        step();
        chk("boot_redir_pc", id_pc, 32'd8);
        chk("boot_redir_instr", id_instr, 32'h0031_0213);
        repeat (2) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Program-counter and fetch stage that drives the instruction memory's `pc` input.
- Captures the returned word into an IF/ID pipeline register, with a valid/ready handshake toward decode.
- Handles branch/jump redirects with a flush, downstream back-pressure, and out-of-range or misaligned PCs via a fault state.
- Sits between the execute/branch-resolution logic, which supplies redirects, and the decode stage, which consumes `id_*`.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- IMEM_BYTES, 164, size of the instruction memory in bytes (41 words); any PC >= IMEM_BYTES is out of range.
- NOP_INSTR, 32'h0000_0013, ADDI x0,x0,0; inserted on reset and in place of faulting fetches.

Ports:
- clk  in  1  single rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- imem_addr  out  32  PC sent to the instruction memory; combinational copy of pc_q.
- imem_rdata  in  32  instruction returned by the memory in the same cycle (combinational read).
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_pc  in  32  target PC, sampled when redirect_valid=1.
- id_ready  in  1  decode can accept the IF/ID contents.
- id_valid  out  1  IF/ID register holds a live instruction.
- id_pc  out  32  PC of the held instruction.
- id_instr  out  32  held instruction word.
- id_pc_plus4  out  32  id_pc+4, modulo 2^32.
- id_fault  out  1  held instruction is a fetch fault; id_instr=NOP_INSTR.
- fetch_count  out  32  number of completed IF->ID transfers; wraps.

Behaviour:
- Reset (async, rst_n=0):
  - pc_q=RESET_PC, state=BOOT.
  - id_valid=0, id_pc=0, id_instr=NOP_INSTR, id_pc_plus4=0, id_fault=0, fetch_count=0.
- FSM states: BOOT, RUN, FAULT.
  - BOOT: one idle cycle after reset release, no fetch; then -> RUN.
  - RUN: fetch when `advance = !id_valid || id_ready`.
  - FAULT: no fetch, pc_q holds, id_valid drops once the fault instruction is consumed; exits only on redirect.
- Fetch in RUN with advance=1 and no redirect:
  - id_valid<=1, id_pc<=pc_q, id_pc_plus4<=pc_q+4.
  - If pc_q < IMEM_BYTES: id_instr<=imem_rdata, id_fault<=0, pc_q<=pc_q+4.
  - Else: id_instr<=NOP_INSTR, id_fault<=1, pc_q holds, state->FAULT.
- Stall: in RUN with id_valid=1 and id_ready=0, all id_* and pc_q hold. imem_addr stays stable, so the memory output is stable.
- Handshake accounting:
  - A transfer occurs when id_valid=1 and id_ready=1; fetch_count increments by 1 per transfer.
  - If no new fetch loads the register, id_valid<=0.
- Redirect (any state, highest priority):
  - id_valid<=0, flushing the held and in-flight instruction.
  - If redirect_pc[1:0]==0: pc_q<=redirect_pc, state->RUN.
  - If misaligned: pc_q<=redirect_pc, state->FAULT, and the IF/ID register is loaded next cycle with id_valid=1, id_fault=1, id_instr=NOP_INSTR, id_pc=redirect_pc. The FAULT state performs this single load once.
  - No fetch occurs in the redirect cycle. The first instruction from the target appears in IF/ID one cycle after the redirect.
- Simultaneous redirect and transfer (id_valid=1, id_ready=1): the transfer counts in fetch_count, and the redirect then flushes.
- Redirect during BOOT: accepted; BOOT is skipped.
- PC arithmetic is 32-bit unsigned with wrap-around. pc_q never advances past the first out-of-range address.
- Latency: redirect or reset-release to first id_valid=1 is 2 cycles from reset and 1 cycle from redirect. Throughput is 1 instruction/cycle when id_ready=1.
- Reset asserted mid-stall or mid-FAULT immediately returns all outputs to reset values.

Test Plan:
- Release reset, memory words 0..3 = 00c10093, 00208193, 00310213, 00418293, id_ready=1 -> id_valid rises at cycle 2; id_pc sequence 0,4,8,12 with the matching words; fetch_count=4 after 4 transfers.
- Hold id_ready=0 for 3 cycles while id_valid=1 at id_pc=8 -> id_pc, id_instr and imem_addr stay constant; fetch_count does not change; resume and the next id_pc is 12.
- redirect_valid=1, redirect_pc=0x40 while id_valid=1 and id_ready=1 -> fetch_count+1, id_valid=0 the next cycle, then id_pc=0x40 with mem[16].
- redirect_pc=0x42 -> id_fault=1, id_instr=00000013, id_pc=0x42; no further fetch until redirect_pc=0x0, which resumes at pc 0.
- Run sequentially to pc=160 then 164 -> the word at 160 is delivered normally; 164 yields id_fault=1 with NOP, pc_q holds at 164, and state stays FAULT.
- Assert rst_n=0 during a stall with id_valid=1 -> outputs immediately return to reset values asynchronously; BOOT repeats after release.
